// File: rtl/yubex_la_pkg.sv
// Shared encodings for the multi-channel logic analyzer: FSM states and trigger modes.
package yubex_la_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } la_state_e;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'b00;
  localparam logic [1:0] TRIG_RISING    = 2'b01;
  localparam logic [1:0] TRIG_FALLING   = 2'b10;
  localparam logic [1:0] TRIG_ANY       = 2'b11;

endpackage

// File: rtl/yubex_edge_stretch.sv
// Stretches a one-cycle edge strobe into a flag that stays high for HOLD_CYCLES cycles.
module yubex_edge_stretch #(
  parameter int HOLD_CYCLES = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic edge_i,
  output logic flag_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (edge_i) begin
      cnt_d = CNT_W'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign flag_o = (cnt_q != '0);

endmodule

// File: rtl/yubex_multi_logic_analyzer.sv
// Multi-channel logic analyzer: synchronised levels, stretched edge flags and a
// triggered DEPTH-word capture buffer read out one word per request.
module yubex_multi_logic_analyzer
  import yubex_la_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 200,
  parameter int DEPTH       = 16,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] data_in,
  input  logic                arm,
  input  logic [SEL_W-1:0]    trig_sel,
  input  logic [1:0]          trig_mode,
  input  logic                rd_req,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_flag,
  output logic [CHANNELS-1:0] fall_flag,
  output logic [1:0]          state_out,
  output logic [CHANNELS-1:0] rd_data,
  output logic                rd_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAD_W = 1 << SEL_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q, s, rise, fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    yubex_edge_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_rise (
      .clk(clk), .rst(rst), .edge_i(rise[c]), .flag_o(rise_flag[c])
    );
    yubex_edge_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_fall (
      .clk(clk), .rst(rst), .edge_i(fall[c]), .flag_o(fall_flag[c])
    );
  end

  // Zero-padding to a power of two makes out-of-range selects read as "no edge".
  logic [PAD_W-1:0] rise_pad, fall_pad;
  logic             trig_hit;

  assign rise_pad = PAD_W'(rise);
  assign fall_pad = PAD_W'(fall);

  always_comb begin
    case (trig_mode)
      TRIG_IMMEDIATE: trig_hit = 1'b1;
      TRIG_RISING:    trig_hit = rise_pad[trig_sel];
      TRIG_FALLING:   trig_hit = fall_pad[trig_sel];
      default:        trig_hit = rise_pad[trig_sel] | fall_pad[trig_sel];
    endcase
  end

  la_state_e        state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr;
  logic             wr_en;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_en    = 1'b0;
    wr_addr  = wr_ptr_q;
    case (state_q)
      ST_IDLE: if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (trig_hit) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = PTR_W'(1);
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        wr_en = 1'b1;
        if (wr_ptr_q == LAST_PTR) begin
          wr_ptr_d = '0;
          state_d  = ST_DONE;
        end else begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end
      ST_DONE: begin
        // Re-arming takes priority over a read in the same cycle.
        if (arm) begin
          rd_ptr_d = '0;
          state_d  = ST_ARMED;
        end else if (rd_req) begin
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the capture buffer is deliberately not reset; every word is rewritten before
  // DONE exposes it, and a reset-free array can map onto plain RAM.
  logic [CHANNELS-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= s;
  end

  assign level_out = s;
  assign state_out = state_q;
  assign rd_valid  = (state_q == ST_DONE);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_yubex_multi_logic_analyzer.sv
// Self-checking bench for yubex_multi_logic_analyzer: flags, triggers, capture/readout, reset.
module tb_yubex_multi_logic_analyzer;
  import yubex_la_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] data_in = '0;
  logic       arm = 1'b0;
  logic [1:0] trig_sel = '0, trig_mode = '0;
  logic       rd_req = 1'b0;
  logic [3:0] level_out, rise_flag, fall_flag, rd_data;
  logic [1:0] state_out;
  logic       rd_valid;

  logic [2:0] data3 = '0;
  logic       arm3 = 1'b0, rd_req3 = 1'b0;
  logic [1:0] sel3 = '0, mode3 = '0;
  logic [2:0] level3, rise3, fall3, rd_data3;
  logic [1:0] state3;
  logic       valid3;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  yubex_multi_logic_analyzer #(
    .CHANNELS(4), .SYNC_STAGES(2), .HOLD_CYCLES(5), .DEPTH(8)
  ) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .arm(arm), .trig_sel(trig_sel),
    .trig_mode(trig_mode), .rd_req(rd_req), .level_out(level_out),
    .rise_flag(rise_flag), .fall_flag(fall_flag), .state_out(state_out),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  yubex_multi_logic_analyzer #(
    .CHANNELS(3), .SYNC_STAGES(2), .HOLD_CYCLES(5), .DEPTH(8)
  ) u_dut3 (
    .clk(clk), .rst(rst), .data_in(data3), .arm(arm3), .trig_sel(sel3),
    .trig_mode(mode3), .rd_req(rd_req3), .level_out(level3),
    .rise_flag(rise3), .fall_flag(fall3), .state_out(state3),
    .rd_data(rd_data3), .rd_valid(valid3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] want, input string what);
    int n = 0;
    while (state_out !== want && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (state_out !== want) begin
      bad++;
      $display("FAIL %s state=%b want=%b (timed out)", what, state_out, want);
    end
  endtask

  task automatic read_words(input int n, input string what);
    logic [3:0] exp;
    for (int k = 0; k < n; k++) begin
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
      total++;
      if ({rd_valid, rd_data} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL %s word%0d got valid=%b data=%h want valid=1 data=%h",
                 what, k, rd_valid, rd_data, exp);
      end
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if ({level_out, rise_flag, fall_flag, rd_data, state_out, rd_valid} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got lvl=%h r=%h f=%h d=%h st=%b v=%b want all 0",
               level_out, rise_flag, fall_flag, rd_data, state_out, rd_valid);
    end
    rst = 1'b0;
    repeat (4) tick();
    total++;
    if ({state_out, rd_valid, rd_data} !== '0) begin
      bad++;
      $display("FAIL reset_release got st=%b v=%b d=%h want 00/0/0", state_out, rd_valid, rd_data);
    end
  endtask

  task automatic test_edge_stretch();
    logic [11:0] exp;
    // Single rise on channel 1, applied before edge 1.
    for (int j = 1; j <= 9; j++) begin
      data_in = 4'b0010;
      tick();
      exp = {((j >= 2) ? 4'b0010 : 4'b0000), ((j >= 3 && j <= 7) ? 4'b0010 : 4'b0000), 4'b0000};
      total++;
      if ({level_out, rise_flag, fall_flag} !== exp) begin
        bad++;
        $display("FAIL stretch_single edge%0d got lvl/rise/fall=%h want %h",
                 j, {level_out, rise_flag, fall_flag}, exp);
      end
    end
    data_in = '0;
    repeat (12) tick();
    // Rise loads at edge 3, a second rise reloads at edge 6 (hold cycle 3), fall loads at 5.
    for (int j = 1; j <= 12; j++) begin
      data_in = (j == 3) ? 4'b0000 : 4'b0010;
      tick();
      exp = {((j == 1 || j == 4) ? 4'b0000 : 4'b0010),
             ((j >= 3 && j <= 10) ? 4'b0010 : 4'b0000),
             ((j >= 5 && j <= 9) ? 4'b0010 : 4'b0000)};
      total++;
      if ({level_out, rise_flag, fall_flag} !== exp) begin
        bad++;
        $display("FAIL stretch_retrig edge%0d got lvl/rise/fall=%h want %h",
                 j, {level_out, rise_flag, fall_flag}, exp);
      end
    end
    data_in = '0;
    repeat (12) tick();
  endtask

  task automatic test_rising_trigger();
    logic [3:0] steps [9] = '{4'h0, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hC, 4'hD};
    trig_sel  = 2'd2;
    trig_mode = TRIG_RISING;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    total++;
    if (state_out !== ST_ARMED) begin
      bad++;
      $display("FAIL rise_armed state=%b want=01", state_out);
    end
    for (int k = 0; k < 9; k++) begin
      data_in = steps[k];
      if (k > 0) exp_q.push_back(steps[k]);
      tick();
    end
    wait_state(ST_DONE, "rise_done");
    read_words(8, "rise_read");
    total++;
    if ({state_out, rd_valid, rd_data} !== '0) begin
      bad++;
      $display("FAIL rise_after_read got st=%b v=%b d=%h want 00/0/0", state_out, rd_valid, rd_data);
    end
  endtask

  task automatic test_immediate();
    logic [1:0] exp_st;
    logic [3:0] v;
    trig_mode = TRIG_IMMEDIATE;
    trig_sel  = 2'd0;
    exp_q.delete();
    // rd_req is held high for the whole capture; it must not disturb the readout.
    for (int i = 0; i <= 9; i++) begin
      v = 4'(i * 7 + 3);
      data_in = v;
      arm     = (i == 1);
      rd_req  = (i >= 3);
      if (i <= 7) exp_q.push_back(v);
      tick();
      exp_st = (i == 0) ? ST_IDLE : (i == 1) ? ST_ARMED : (i <= 8) ? ST_CAPTURE : ST_DONE;
      total++;
      if (state_out !== exp_st) begin
        bad++;
        $display("FAIL imm_state cycle%0d got=%b want=%b", i, state_out, exp_st);
      end
    end
    rd_req = 1'b0;
    arm    = 1'b0;
  endtask

  task automatic test_arm_read_collision();
    logic [3:0] steps [9] = '{4'h2, 4'h3, 4'hA, 4'h1, 4'h7, 4'hF, 4'h5, 4'hB, 4'h3};
    read_words(3, "imm_read");
    trig_mode = TRIG_RISING;
    trig_sel  = 2'd0;
    arm = 1'b1;
    rd_req = 1'b1;
    tick();
    arm = 1'b0;
    rd_req = 1'b0;
    total++;
    if ({state_out, rd_valid, rd_data} !== {2'b01, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL collide got st=%b v=%b d=%h want 01/0/0", state_out, rd_valid, rd_data);
    end
    exp_q.delete();
    for (int k = 0; k < 9; k++) begin
      data_in = steps[k];
      if (k > 0) exp_q.push_back(steps[k]);
      tick();
    end
    wait_state(ST_DONE, "collide_done");
    read_words(8, "collide_read");
    total++;
    if (state_out !== ST_IDLE) begin
      bad++;
      $display("FAIL collide_idle state=%b want=00", state_out);
    end
  endtask

  task automatic test_out_of_range();
    sel3  = 2'd3;
    mode3 = TRIG_ANY;
    arm3  = 1'b1;
    tick();
    arm3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      data3 = ~data3;
      tick();
      total++;
      if (state3 !== ST_ARMED) begin
        bad++;
        $display("FAIL oor_state cycle%0d got=%b want=01", k, state3);
      end
    end
    total++;
    if ({rise3, fall3} !== 6'b111111) begin
      bad++;
      $display("FAIL oor_flags got rise=%b fall=%b want 111/111", rise3, fall3);
    end
  endtask

  task automatic test_reset_midrun();
    trig_mode = TRIG_IMMEDIATE;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data_in = ~data_in;
      tick();
    end
    total++;
    if (state_out !== ST_CAPTURE) begin
      bad++;
      $display("FAIL midrun_pre state=%b want=10", state_out);
    end
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({level_out, rise_flag, fall_flag, rd_data, state_out, rd_valid, state3} !== '0) begin
      bad++;
      $display("FAIL midrun_reset got lvl=%h r=%h f=%h d=%h st=%b v=%b st3=%b want all 0",
               level_out, rise_flag, fall_flag, rd_data, state_out, rd_valid, state3);
    end
    tick();
    rst = 1'b0;
    repeat (10) tick();
    total++;
    if ({state_out, rd_valid, state3} !== '0) begin
      bad++;
      $display("FAIL midrun_after got st=%b v=%b st3=%b want idle", state_out, rd_valid, state3);
    end
  endtask

  initial begin
    test_reset();
    test_edge_stretch();
    test_rising_trigger();
    test_immediate();
    test_arm_read_collision();
    test_out_of_range();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
